// File: rtl/modulo_arbitro_buffer_rolhas.sv
// Cork buffer arbiter: owns the secondary and principal cork counts, arbitrates operator loads
// against automatic refills round-robin, moves one cork per clock and applies sealing consumption.
module modulo_arbitro_buffer_rolhas #(
  parameter int SEC_MAX      = 99,
  parameter int PRIN_MAX     = 20,
  parameter int XFER_QTY     = 15,
  parameter int REFILL_LEVEL = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       op_req,
  input  logic [6:0] op_qty,
  input  logic       seal,
  output logic [6:0] sec_count,
  output logic [4:0] prin_count,
  output logic       op_ack,
  output logic       op_nack,
  output logic       xfer_done,
  output logic       busy,
  output logic       ro,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_XFER = 2'b10
  } state_t;

  typedef enum logic {
    G_OP = 1'b0,
    G_RF = 1'b1
  } grant_t;

  localparam logic [7:0] SEC_MAX_W  = 8'(SEC_MAX);
  localparam logic [4:0] PRIN_MAX_W = 5'(PRIN_MAX);
  localparam logic [6:0] XFER_SEC_W = 7'(XFER_QTY);
  localparam logic [4:0] XFER_PRN_W = 5'(XFER_QTY);
  localparam logic [4:0] REFILL_W   = 5'(REFILL_LEVEL);

  state_t     state_q, state_d;
  grant_t     last_q, last_d;
  logic [6:0] sec_q, sec_d;
  logic [4:0] prin_q, prin_d;
  logic [6:0] rem_q, rem_d;
  logic       ack_q, ack_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;

  logic       rf_pend;
  logic       grant_op;
  logic       grant_rf;
  logic       prin_inc;
  logic       seal_dec;
  logic [4:0] prin_room;
  logic [7:0] op_sum;

  // The principal buffer never exceeds PRIN_MAX, so the headroom subtraction cannot underflow.
  assign prin_room = PRIN_MAX_W - prin_q;
  assign rf_pend   = (prin_q < REFILL_W) && (sec_q >= XFER_SEC_W) && (prin_room >= XFER_PRN_W);
  assign op_sum    = {1'b0, sec_q} + {1'b0, op_qty};

  // When both requesters are pending, the one not served last time wins.
  assign grant_op  = op_req  && (!rf_pend || (last_q == G_RF));
  assign grant_rf  = rf_pend && (!op_req  || (last_q == G_OP));

  assign seal_dec  = seal && (prin_q != 5'd0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    sec_d    = sec_q;
    rem_d    = rem_q;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
    done_d   = 1'b0;
    prin_inc = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (grant_op) begin
            last_d = G_OP;
            if ((op_qty == 7'd0) || (op_sum > SEC_MAX_W)) begin
              nack_d = 1'b1;
            end else begin
              ack_d   = 1'b1;
              rem_d   = op_qty;
              state_d = S_LOAD;
            end
          end else if (grant_rf) begin
            last_d  = G_RF;
            rem_d   = XFER_SEC_W;
            state_d = S_XFER;
          end
        end
      end
      S_LOAD: begin
        sec_d = sec_q + 7'd1;
        rem_d = rem_q - 7'd1;
        if (rem_q == 7'd1) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        sec_d    = sec_q - 7'd1;
        prin_inc = 1'b1;
        rem_d    = rem_q - 7'd1;
        if (rem_q == 7'd1) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A seal in the same cycle as a refill cork cancels it out on the principal count.
    prin_d = prin_q + {4'd0, prin_inc} - {4'd0, seal_dec};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      last_q  <= G_OP;
      sec_q   <= 7'd0;
      prin_q  <= 5'd0;
      rem_q   <= 7'd0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sec_q   <= sec_d;
      prin_q  <= prin_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

  assign sec_count  = sec_q;
  assign prin_count = prin_q;
  assign op_ack     = ack_q;
  assign op_nack    = nack_q;
  assign xfer_done  = done_q;
  assign busy       = (state_q != S_IDLE);
  assign ro         = (prin_q == 5'd0);
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_modulo_arbitro_buffer_rolhas.sv
// Directed bench for the cork buffer arbiter: one task per scenario, inline comparisons
// against hand-computed values, single summary line at the end.
module tb_modulo_arbitro_buffer_rolhas;

  logic       clk;
  logic       clr;
  logic       enable;
  logic       op_req;
  logic [6:0] op_qty;
  logic       seal;
  logic [6:0] sec_count;
  logic [4:0] prin_count;
  logic       op_ack;
  logic       op_nack;
  logic       xfer_done;
  logic       busy;
  logic       ro;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  modulo_arbitro_buffer_rolhas dut (
    .clk        (clk),
    .clr        (clr),
    .enable     (enable),
    .op_req     (op_req),
    .op_qty     (op_qty),
    .seal       (seal),
    .sec_count  (sec_count),
    .prin_count (prin_count),
    .op_ack     (op_ack),
    .op_nack    (op_nack),
    .xfer_done  (xfer_done),
    .busy       (busy),
    .ro         (ro),
    .fsm_state  (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; enable = 1'b0; op_req = 1'b0; op_qty = 7'd0; seal = 1'b0;
    tick();
    clr = 1'b1;
    n_cmp++;
    if ({sec_count, prin_count, fsm_state, busy} !== {7'd0, 5'd0, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_counts: got sec=%0d prin=%0d st=%b busy=%b, want 0 0 00 0",
               sec_count, prin_count, fsm_state, busy);
    end
    n_cmp++;
    if ({op_ack, op_nack, xfer_done, ro} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_flags: got ack/nack/done/ro=%b, want 0001",
               {op_ack, op_nack, xfer_done, ro});
    end
  endtask

  task automatic test_load();
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd30;
    tick();
    n_cmp++;
    if ({op_ack, op_nack, fsm_state, busy, sec_count} !== {1'b1, 1'b0, 2'b01, 1'b1, 7'd0}) begin
      n_bad++;
      $display("FAIL load_grant: got ack=%b nack=%b st=%b busy=%b sec=%0d, want 1 0 01 1 0",
               op_ack, op_nack, fsm_state, busy, sec_count);
    end
    op_req = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_cmp++;
      if ({sec_count, xfer_done, op_ack} !== {7'(k), (k == 30), 1'b0}) begin
        n_bad++;
        $display("FAIL load_step%0d: got sec=%0d done=%b ack=%b, want %0d %b 0",
                 k, sec_count, xfer_done, op_ack, k, (k == 30));
      end
    end
    n_cmp++;
    if (fsm_state !== 2'b00) begin
      n_bad++;
      $display("FAIL load_end_state: got %b, want 00", fsm_state);
    end
  endtask

  // sec=30, prin=0 right after the load: the refill is granted without any request.
  task automatic test_refill();
    tick();
    n_cmp++;
    if ({fsm_state, sec_count, prin_count, ro} !== {2'b10, 7'd30, 5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL refill_grant: got st=%b sec=%0d prin=%0d ro=%b, want 10 30 0 1",
               fsm_state, sec_count, prin_count, ro);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_cmp++;
      if ({sec_count, prin_count, ro, xfer_done} !== {7'(30 - k), 5'(k), 1'b0, (k == 15)}) begin
        n_bad++;
        $display("FAIL refill_step%0d: got sec=%0d prin=%0d ro=%b done=%b, want %0d %0d 0 %b",
                 k, sec_count, prin_count, ro, xfer_done, 30 - k, k, (k == 15));
      end
    end
    tick();
    n_cmp++;
    if ({fsm_state, sec_count, prin_count} !== {2'b00, 7'd15, 5'd15}) begin
      n_bad++;
      $display("FAIL refill_idle: got st=%b sec=%0d prin=%0d, want 00 15 15",
               fsm_state, sec_count, prin_count);
    end
  endtask

  // Last grant was RF: with both pending OP wins; op_req held through the load then loses to RF.
  task automatic test_round_robin();
    enable = 1'b0; seal = 1'b1;
    for (int k = 0; k < 13; k++) tick();
    seal = 1'b0;
    n_cmp++;
    if ({sec_count, prin_count, fsm_state} !== {7'd15, 5'd2, 2'b00}) begin
      n_bad++;
      $display("FAIL rr_setup: got sec=%0d prin=%0d st=%b, want 15 2 00",
               sec_count, prin_count, fsm_state);
    end
    enable = 1'b1; op_req = 1'b1; op_qty = 7'd10;
    tick();
    n_cmp++;
    if ({op_ack, fsm_state} !== {1'b1, 2'b01}) begin
      n_bad++;
      $display("FAIL rr_op_first: got ack=%b st=%b, want 1 01", op_ack, fsm_state);
    end
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if ({sec_count, xfer_done, fsm_state} !== {7'd25, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL rr_load_end: got sec=%0d done=%b st=%b, want 25 1 00",
               sec_count, xfer_done, fsm_state);
    end
    tick();
    n_cmp++;
    if ({op_ack, op_nack, fsm_state} !== {1'b0, 1'b0, 2'b10}) begin
      n_bad++;
      $display("FAIL rr_rf_second: got ack=%b nack=%b st=%b, want 0 0 10",
               op_ack, op_nack, fsm_state);
    end
    op_req = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    n_cmp++;
    if ({sec_count, prin_count, xfer_done} !== {7'd10, 5'd17, 1'b1}) begin
      n_bad++;
      $display("FAIL rr_xfer_end: got sec=%0d prin=%0d done=%b, want 10 17 1",
               sec_count, prin_count, xfer_done);
    end
  endtask

  task automatic test_limits();
    op_req = 1'b1; op_qty = 7'd85;
    tick();
    op_req = 1'b0;
    for (int k = 0; k < 85; k++) tick();
    n_cmp++;
    if ({sec_count, xfer_done} !== {7'd95, 1'b1}) begin
      n_bad++;
      $display("FAIL lim_fill95: got sec=%0d done=%b, want 95 1", sec_count, xfer_done);
    end
    op_req = 1'b1; op_qty = 7'd5;
    tick();
    op_req = 1'b0;
    n_cmp++;
    if ({op_nack, op_ack, fsm_state} !== {1'b1, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL lim_over_nack: got nack=%b ack=%b st=%b, want 1 0 00",
               op_nack, op_ack, fsm_state);
    end
    tick();
    n_cmp++;
    if ({sec_count, op_nack} !== {7'd95, 1'b0}) begin
      n_bad++;
      $display("FAIL lim_over_hold: got sec=%0d nack=%b, want 95 0", sec_count, op_nack);
    end
    op_req = 1'b1; op_qty = 7'd4;
    tick();
    op_req = 1'b0;
    n_cmp++;
    if ({op_ack, op_nack} !== 2'b10) begin
      n_bad++;
      $display("FAIL lim_exact_ack: got ack=%b nack=%b, want 1 0", op_ack, op_nack);
    end
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if ({sec_count, xfer_done} !== {7'd99, 1'b1}) begin
      n_bad++;
      $display("FAIL lim_full99: got sec=%0d done=%b, want 99 1", sec_count, xfer_done);
    end
    op_req = 1'b1; op_qty = 7'd0;
    tick();
    op_req = 1'b0;
    n_cmp++;
    if ({op_nack, op_ack} !== 2'b10) begin
      n_bad++;
      $display("FAIL lim_zero_nack: got nack=%b ack=%b, want 1 0", op_nack, op_ack);
    end
    op_req = 1'b1; op_qty = 7'd1;
    tick();
    op_req = 1'b0;
    n_cmp++;
    if ({op_nack, sec_count} !== {1'b1, 7'd99}) begin
      n_bad++;
      $display("FAIL lim_full_nack: got nack=%b sec=%0d, want 1 99", op_nack, sec_count);
    end
  endtask

  task automatic test_seal();
    enable = 1'b0; seal = 1'b1;
    for (int k = 0; k < 13; k++) tick();
    seal = 1'b0;
    n_cmp++;
    if (prin_count !== 5'd4) begin
      n_bad++;
      $display("FAIL seal_drain: got prin=%0d, want 4", prin_count);
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (fsm_state !== 2'b10) begin
      n_bad++;
      $display("FAIL seal_xfer_grant: got st=%b, want 10", fsm_state);
    end
    seal = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if ({sec_count, prin_count} !== {7'(99 - k), 5'd4}) begin
        n_bad++;
        $display("FAIL seal_cancel%0d: got sec=%0d prin=%0d, want %0d 4",
                 k, sec_count, prin_count, 99 - k);
      end
    end
    seal = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    n_cmp++;
    if ({sec_count, prin_count, xfer_done} !== {7'd84, 5'd16, 1'b1}) begin
      n_bad++;
      $display("FAIL seal_xfer_end: got sec=%0d prin=%0d done=%b, want 84 16 1",
               sec_count, prin_count, xfer_done);
    end
    enable = 1'b0; seal = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    n_cmp++;
    if ({prin_count, ro} !== {5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL seal_to_zero: got prin=%0d ro=%b, want 0 1", prin_count, ro);
    end
    tick();
    seal = 1'b0;
    n_cmp++;
    if ({prin_count, ro} !== {5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL seal_at_zero: got prin=%0d ro=%b, want 0 1", prin_count, ro);
    end
  endtask

  task automatic test_abort_and_enable();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) tick();
    n_cmp++;
    if ({fsm_state, sec_count, prin_count} !== {2'b10, 7'd76, 5'd8}) begin
      n_bad++;
      $display("FAIL abort_setup: got st=%b sec=%0d prin=%0d, want 10 76 8",
               fsm_state, sec_count, prin_count);
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    n_cmp++;
    if ({fsm_state, sec_count, prin_count, xfer_done, ro} !== {2'b00, 7'd0, 5'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL abort_clear: got st=%b sec=%0d prin=%0d done=%b ro=%b, want 00 0 0 0 1",
               fsm_state, sec_count, prin_count, xfer_done, ro);
    end
    tick();
    n_cmp++;
    if ({fsm_state, xfer_done, sec_count} !== {2'b00, 1'b0, 7'd0}) begin
      n_bad++;
      $display("FAIL abort_no_resume: got st=%b done=%b sec=%0d, want 00 0 0",
               fsm_state, xfer_done, sec_count);
    end
    op_req = 1'b1; op_qty = 7'd20;
    tick();
    op_req = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    enable = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    n_cmp++;
    if ({sec_count, xfer_done, fsm_state} !== {7'd20, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL en_load_completes: got sec=%0d done=%b st=%b, want 20 1 00",
               sec_count, xfer_done, fsm_state);
    end
    tick();
    tick();
    n_cmp++;
    if ({fsm_state, busy, sec_count, prin_count} !== {2'b00, 1'b0, 7'd20, 5'd0}) begin
      n_bad++;
      $display("FAIL en_no_grant: got st=%b busy=%b sec=%0d prin=%0d, want 00 0 20 0",
               fsm_state, busy, sec_count, prin_count);
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (fsm_state !== 2'b10) begin
      n_bad++;
      $display("FAIL en_resume_grant: got st=%b, want 10", fsm_state);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_refill();
    test_round_robin();
    test_limits();
    test_seal();
    test_abort_and_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
